// File: rtl/neopixel_pkg.sv
// Shared types and helpers for the NeoPixel frame source: modes, GRB payload,
// FSM states and hue arithmetic.
package neopixel_pkg;

  localparam logic [1:0] MODE_HOST    = 2'd0;
  localparam logic [1:0] MODE_CHASE   = 2'd1;
  localparam logic [1:0] MODE_RAINBOW = 2'd2;
  localparam logic [1:0] MODE_OFF     = 2'd3;

  localparam int unsigned HUE_RANGE = 768;
  localparam int unsigned HUE_W     = 10;
  localparam int unsigned COMP_W    = 8;

  typedef struct packed {
    logic [COMP_W-1:0] g;
    logic [COMP_W-1:0] r;
    logic [COMP_W-1:0] b;
  } grb_t;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_FILL  = 2'd2
  } state_t;

  function automatic grb_t pack_grb(input logic [COMP_W-1:0] g,
                                    input logic [COMP_W-1:0] r,
                                    input logic [COMP_W-1:0] b);
    grb_t w;
    w.g = g;
    w.r = r;
    w.b = b;
    return w;
  endfunction

  // (a + b) mod HUE_RANGE for operands already below HUE_RANGE
  function automatic logic [HUE_W-1:0] add_hue(input logic [HUE_W-1:0] a,
                                               input logic [HUE_W-1:0] b);
    logic [HUE_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= (HUE_W+1)'(HUE_RANGE)) s = s - (HUE_W+1)'(HUE_RANGE);
    return s[HUE_W-1:0];
  endfunction

endpackage

// File: rtl/neopixel_frame_src_if.sv
// Host write port and serializer read port of the pixel frame source.
interface neopixel_frame_src_if;
  import neopixel_pkg::*;

  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_addr;
  grb_t       wr_data;
  logic [7:0] ram_rd_addr;
  grb_t       ram_rd_data;

  modport master (output wr_valid, wr_addr, wr_data, ram_rd_addr,
                  input  wr_ready, ram_rd_data);
  modport slave  (input  wr_valid, wr_addr, wr_data, ram_rd_addr,
                  output wr_ready, ram_rd_data);
endinterface

// File: rtl/neopixel_hue2grb.sv
// Combinational hue wheel: 0..767 hue to a GRB word, each component right-shifted.
module neopixel_hue2grb
  import neopixel_pkg::*;
(
  input  logic [HUE_W-1:0] hue_i,
  input  logic [2:0]       shift_i,
  output grb_t             grb_c_o
);

  logic [COMP_W-1:0] f;
  logic [COMP_W-1:0] fi;
  logic [COMP_W-1:0] r;
  logic [COMP_W-1:0] g;
  logic [COMP_W-1:0] b;

  always_comb begin
    f  = hue_i[COMP_W-1:0];
    fi = ~f;
    r  = '0;
    g  = '0;
    b  = '0;
    case (hue_i[HUE_W-1:COMP_W])
      2'd0: begin r = fi; g = f; end
      2'd1: begin g = fi; b = f; end
      2'd2: begin b = fi; r = f; end
      default: ;
    endcase
    grb_c_o = pack_grb(g >> shift_i, r >> shift_i, b >> shift_i);
  end

endmodule

// File: rtl/neopixel_frame_src.sv
// Pixel frame source: owns the GRB pixel memory, serves the serializer read port
// and refills the buffer from the host port or a chase/rainbow/off animation.
module neopixel_frame_src
  import neopixel_pkg::*;
#(
  parameter int unsigned NUM_OF_PIXELS = 8,
  parameter logic [15:0] STEP_TICKS    = 16'd5000,
  parameter int unsigned HUE_STEP      = 96,
  parameter logic [23:0] CHASE_COLOR   = 24'h100000,
  parameter int unsigned BRIGHT_SHIFT  = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ten_us,
  input  logic [1:0]           mode,
  output logic                 step_pulse,
  neopixel_frame_src_if.slave  bus
);

  localparam int unsigned     AW    = (NUM_OF_PIXELS > 1) ? $clog2(NUM_OF_PIXELS) : 1;
  localparam logic [7:0]      NUM8  = 8'(NUM_OF_PIXELS);
  localparam logic [7:0]      LAST8 = 8'(NUM_OF_PIXELS - 1);
  localparam logic [HUE_W-1:0] HSTEP = HUE_W'(HUE_STEP);

  grb_t             mem_q [NUM_OF_PIXELS];
  state_t           state_q, state_d;
  logic [7:0]       idx_q, idx_d, pos_q, pos_d;
  logic [HUE_W-1:0] base_q, base_d, hue_q, hue_d, base_nx;
  logic [15:0]      tick_q, tick_d;
  logic             step_q, step_d, pending_q, pending_d, wr_ready_q, wr_ready_d;
  logic [1:0]       mode_q, fmode_q, fmode_d;
  grb_t             rd_q, hue_grb_c, pix_c, wr_data_c;
  logic             wr_en_c, trig_a_c, trig_b_c;
  logic [7:0]       wr_addr_c;

  neopixel_hue2grb u_hue (
    .hue_i   (hue_q),
    .shift_i (3'(BRIGHT_SHIFT)),
    .grb_c_o (hue_grb_c)
  );

  // Animation pixel for the current fill index, in the mode the pass started with
  always_comb begin
    pix_c = '0;
    case (fmode_q)
      MODE_CHASE:   pix_c = (idx_q == pos_q) ? grb_t'(CHASE_COLOR) : grb_t'('0);
      MODE_RAINBOW: pix_c = hue_grb_c;
      default:      pix_c = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pos_d     = pos_q;
    base_d    = base_q;
    hue_d     = hue_q;
    pending_d = pending_q;
    fmode_d   = fmode_q;
    tick_d    = tick_q;
    step_d    = 1'b0;
    base_nx   = base_q;
    wr_en_c   = 1'b0;
    wr_addr_c = idx_q;
    wr_data_c = '0;
    trig_a_c  = 1'b0;
    trig_b_c  = 1'b0;

    if (ten_us) begin
      if (tick_q == STEP_TICKS - 16'd1) begin
        tick_d = '0;
        step_d = 1'b1;
      end else begin
        tick_d = tick_q + 16'd1;
      end
    end

    case (state_q)
      ST_CLEAR: begin
        wr_en_c = 1'b1;
        if (step_q) pending_d = 1'b1;
        if (idx_q == LAST8) begin
          idx_d   = '0;
          state_d = ST_IDLE;
        end else begin
          idx_d = idx_q + 8'd1;
        end
      end

      ST_IDLE: begin
        if (bus.wr_valid && wr_ready_q && (bus.wr_addr < NUM8)) begin
          wr_en_c   = 1'b1;
          wr_addr_c = bus.wr_addr;
          wr_data_c = bus.wr_data;
        end
        // fmode_q catches a mode swap that happened while a pass was running
        if (mode != MODE_HOST) begin
          trig_a_c = (mode != mode_q) || (mode != fmode_q);
          trig_b_c = step_q || pending_q;
        end
        if (trig_a_c || trig_b_c) begin
          state_d   = ST_FILL;
          idx_d     = '0;
          fmode_d   = mode;
          pending_d = 1'b0;
          if (trig_b_c && (mode == MODE_CHASE))
            pos_d = (pos_q == LAST8) ? 8'd0 : pos_q + 8'd1;
          if (trig_b_c && (mode == MODE_RAINBOW))
            base_nx = add_hue(base_q, HSTEP);
          base_d = base_nx;
          hue_d  = base_nx;
        end
      end

      ST_FILL: begin
        if (mode == MODE_HOST) begin
          state_d   = ST_IDLE;
          idx_d     = '0;
          pending_d = 1'b0;
        end else begin
          wr_en_c   = 1'b1;
          wr_data_c = pix_c;
          hue_d     = add_hue(hue_q, HSTEP);
          if (step_q) pending_d = 1'b1;
          if (idx_q == LAST8) begin
            idx_d   = '0;
            state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end
      end

      default: state_d = ST_CLEAR;
    endcase

    wr_ready_d = (state_d == ST_IDLE) && (mode == MODE_HOST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_CLEAR;
      idx_q      <= '0;
      pos_q      <= '0;
      base_q     <= '0;
      hue_q      <= '0;
      tick_q     <= '0;
      step_q     <= 1'b0;
      pending_q  <= 1'b0;
      wr_ready_q <= 1'b0;
      mode_q     <= MODE_HOST;
      fmode_q    <= MODE_HOST;
      rd_q       <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      pos_q      <= pos_d;
      base_q     <= base_d;
      hue_q      <= hue_d;
      tick_q     <= tick_d;
      step_q     <= step_d;
      pending_q  <= pending_d;
      wr_ready_q <= wr_ready_d;
      mode_q     <= mode;
      fmode_q    <= fmode_d;
      rd_q       <= (bus.ram_rd_addr < NUM8) ? mem_q[AW'(bus.ram_rd_addr)] : grb_t'('0);
    end
  end

  // Pixel storage has no reset; CLEAR zeroes it after every reset
  always_ff @(posedge clk) begin
    if (wr_en_c) mem_q[AW'(wr_addr_c)] <= wr_data_c;
  end

  assign bus.wr_ready    = wr_ready_q;
  assign bus.ram_rd_data = rd_q;
  assign step_pulse      = step_q;

endmodule

// File: tb/tb_neopixel_frame_src.sv
// Directed bench for neopixel_frame_src: table-driven read-back checks per phase
// plus hand-written sequences for steps, pending, abort and reset.
`timescale 1ns/1ps
module tb_neopixel_frame_src;
  import neopixel_pkg::*;

  typedef struct {
    int          phase;
    logic [7:0]  addr;
    logic [23:0] exp;
  } rd_vec_t;

  logic       clk;
  logic       rst_n;
  logic       ten_us;
  logic [1:0] mode;
  logic       step_pulse;
  int         checks;
  int         failures;
  rd_vec_t    vecs[$];

  neopixel_frame_src_if bus ();

  neopixel_frame_src #(
    .NUM_OF_PIXELS (8),
    .STEP_TICKS    (16'd2),
    .HUE_STEP      (96),
    .CHASE_COLOR   (24'h100000),
    .BRIGHT_SHIFT  (0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ten_us     (ten_us),
    .mode       (mode),
    .step_pulse (step_pulse),
    .bus        (bus.slave)
  );

  initial clk = 1'b0;
  always #42 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic check(input string nm, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic add_vec(input int p, input logic [7:0] a, input logic [23:0] e);
    rd_vec_t v;
    v.phase = p;
    v.addr  = a;
    v.exp   = e;
    vecs.push_back(v);
  endtask

  task automatic run_phase(input int p);
    foreach (vecs[k]) begin
      if (vecs[k].phase == p) begin
        bus.ram_rd_addr = vecs[k].addr;
        tick();
        check($sformatf("p%0d_rd_addr%0d", p, vecs[k].addr), bus.ram_rd_data, vecs[k].exp);
      end
    end
  endtask

  task automatic check_clear_ready(input string nm);
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("%s_ready_c%0d", nm, k), 24'(bus.wr_ready), 24'(k == 8));
    end
  endtask

  task automatic host_write(input logic [7:0] a, input logic [23:0] d);
    int n;
    n = 0;
    bus.wr_valid = 1'b1;
    bus.wr_addr  = a;
    bus.wr_data  = d;
    while (!bus.wr_ready && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) check($sformatf("wr%0d_timeout", a), 24'(bus.wr_ready), 24'd1);
    tick();
    bus.wr_valid = 1'b0;
  endtask

  task automatic do_step(input string nm);
    ten_us = 1'b1;
    tick();
    ten_us = 1'b0;
    tick();
    ten_us = 1'b1;
    tick();
    ten_us = 1'b0;
    check({nm, "_step_hi"}, 24'(step_pulse), 24'd1);
    tick();
    check({nm, "_step_lo"}, 24'(step_pulse), 24'd0);
    ticks(12);
  endtask

  initial begin
    checks          = 0;
    failures        = 0;
    rst_n           = 1'b0;
    ten_us          = 1'b0;
    mode            = MODE_HOST;
    bus.wr_valid    = 1'b0;
    bus.wr_addr     = '0;
    bus.wr_data     = '0;
    bus.ram_rd_addr = '0;

    for (int a = 0; a < 8; a++) add_vec(0, 8'(a), 24'h000000);
    add_vec(0, 8'd9, 24'h000000);
    add_vec(1, 8'd3, 24'h123456); add_vec(1, 8'd9, 24'h000000);
    add_vec(1, 8'd1, 24'h000000); add_vec(1, 8'd4, 24'h000000);
    add_vec(2, 8'd0, 24'h100000); add_vec(2, 8'd1, 24'h000000);
    add_vec(2, 8'd3, 24'h000000); add_vec(2, 8'd7, 24'h000000);
    add_vec(3, 8'd0, 24'h000000); add_vec(3, 8'd1, 24'h100000);
    add_vec(3, 8'd2, 24'h000000);
    add_vec(4, 8'd0, 24'h100000); add_vec(4, 8'd1, 24'h000000);
    add_vec(4, 8'd7, 24'h000000);
    add_vec(5, 8'd0, 24'h00FF00); add_vec(5, 8'd1, 24'h609F00);
    add_vec(5, 8'd2, 24'hC03F00); add_vec(5, 8'd3, 24'hDF0020);
    add_vec(5, 8'd5, 24'h1F00E0); add_vec(5, 8'd7, 24'h00A05F);
    add_vec(6, 8'd0, 24'h609F00); add_vec(6, 8'd2, 24'hDF0020);
    add_vec(6, 8'd7, 24'h00FF00);
    add_vec(7, 8'd0, 24'h000000); add_vec(7, 8'd1, 24'h100000);
    add_vec(7, 8'd2, 24'h000000);
    add_vec(8, 8'd0, 24'h000000); add_vec(8, 8'd1, 24'h100000);
    add_vec(8, 8'd2, 24'h000000); add_vec(8, 8'd3, 24'h7F0080);
    add_vec(8, 8'd4, 24'h1F00E0); add_vec(8, 8'd7, 24'h00FF00);
    add_vec(9, 8'd0, 24'h000000); add_vec(9, 8'd1, 24'h000000);
    add_vec(9, 8'd3, 24'h000000);
    add_vec(10, 8'd0, 24'h100000); add_vec(10, 8'd1, 24'h000000);

    #100;
    check("rst_ready", 24'(bus.wr_ready), 24'd0);
    check("rst_rd_data", bus.ram_rd_data, 24'h000000);
    check("rst_step", 24'(step_pulse), 24'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check_clear_ready("clear0");
    run_phase(0);

    // host write, then one-cycle read latency
    host_write(8'd3, 24'h123456);
    host_write(8'd9, 24'hABCDEF);
    bus.ram_rd_addr = 8'd0;
    tick();
    bus.ram_rd_addr = 8'd3;
    #1;
    check("lat_before_edge", bus.ram_rd_data, 24'h000000);
    tick();
    check("lat_one_cycle", bus.ram_rd_data, 24'h123456);
    run_phase(1);

    // chase
    mode = MODE_CHASE;
    tick();
    check("chase_ready_lo", 24'(bus.wr_ready), 24'd0);
    ticks(12);
    run_phase(2);
    do_step("chase1");
    run_phase(3);
    for (int s = 0; s < 7; s++) do_step($sformatf("chase_w%0d", s));
    run_phase(4);

    // rainbow
    mode = MODE_HOST;
    ticks(2);
    mode = MODE_RAINBOW;
    ticks(12);
    run_phase(5);
    do_step("rain1");
    run_phase(6);

    // two steps land inside one chase pass: one extra fill, pos +1
    ten_us = 1'b1;
    tick();
    ten_us = 1'b0;
    mode = MODE_CHASE;
    tick();
    ten_us = 1'b1;
    ticks(3);
    ten_us = 1'b0;
    ticks(25);
    run_phase(7);

    // abort a chase pass three cycles in by switching to host
    mode = MODE_RAINBOW;
    ticks(12);
    mode = MODE_CHASE;
    ticks(4);
    check("abort_ready_lo", 24'(bus.wr_ready), 24'd0);
    mode = MODE_HOST;
    tick();
    check("abort_ready_hi", 24'(bus.wr_ready), 24'd1);
    run_phase(8);

    // async reset in the middle of a pass
    bus.ram_rd_addr = 8'd1;
    mode = MODE_CHASE;
    ticks(3);
    check("pre_rst_rd", bus.ram_rd_data, 24'h100000);
    rst_n = 1'b0;
    mode  = MODE_HOST;
    #1;
    check("midrst_rd_data", bus.ram_rd_data, 24'h000000);
    check("midrst_ready", 24'(bus.wr_ready), 24'd0);
    ticks(2);
    @(negedge clk);
    rst_n = 1'b1;
    check_clear_ready("clear1");
    run_phase(9);
    mode = MODE_CHASE;
    ticks(12);
    run_phase(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
